// File: rtl/jtag_dtm.sv
// JTAG debug transport module: a TAP controller oversampled on the system clock, with the
// IDCODE, DTMCS, DMI and BYPASS data registers and a single-outstanding DMI request port.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   tclk, tms, tdi, trst  JTAG pins (trst active-low), all asynchronous to clk
//   tdo, tdo_en           JTAG data out and its drive enable, updated on TCK fall
//   dmi_req_*             DMI request (valid/ready, addr, data, op 1=read 2=write)
//   dmi_resp_*            DMI response (valid/ready, data, op 0=ok 2=failed)
module jtag_dtm #(
  parameter logic [31:0] IDCODE = 32'h1000_0001,
  parameter int unsigned ABITS  = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tclk,
  input  logic             tms,
  input  logic             tdi,
  input  logic             trst,
  output logic             tdo,
  output logic             tdo_en,
  output logic             dmi_req_valid,
  input  logic             dmi_req_ready,
  output logic [ABITS-1:0] dmi_req_addr,
  output logic [31:0]      dmi_req_data,
  output logic [1:0]       dmi_req_op,
  input  logic             dmi_resp_valid,
  output logic             dmi_resp_ready,
  input  logic [31:0]      dmi_resp_data,
  input  logic [1:0]       dmi_resp_op
);

  localparam int unsigned DrW  = ABITS + 34;
  localparam int unsigned IdxW = $clog2(DrW);

  localparam logic [4:0] IrIdcode = 5'h01;
  localparam logic [4:0] IrDtmcs  = 5'h10;
  localparam logic [4:0] IrDmi    = 5'h11;

  typedef enum logic [3:0] {
    StTlr, StRti, StSelDr, StCapDr, StShiftDr, StExit1Dr, StPauseDr, StExit2Dr, StUpdDr,
    StSelIr, StCapIr, StShiftIr, StExit1Ir, StPauseIr, StExit2Ir, StUpdIr
  } tap_state_e;

  // Pin synchronizers; bit 1 is the synchronized value.
  logic [1:0] tck_sync_q, tms_sync_q, tdi_sync_q, trst_sync_q;
  logic       tck_prev_q;
  logic       tck_rise, tck_fall, tms_s, tdi_s, trst_s;

  tap_state_e state_q, state_d;

  logic [4:0]       ir_q, ir_d, ir_shift_q, ir_shift_d;
  logic [DrW-1:0]   dr_shift_q, dr_shift_d, dr_capture;
  logic [IdxW-1:0]  dr_msb;
  logic             tdo_q, tdo_d, tdo_en_q, tdo_en_d;

  logic             req_valid_q, req_valid_d, busy_q, busy_d;
  logic [ABITS-1:0] req_addr_q, req_addr_d, last_addr_q, last_addr_d;
  logic [31:0]      req_data_q, req_data_d, last_data_q, last_data_d;
  logic [1:0]       req_op_q, req_op_d, dmistat_q, dmistat_d;

  logic [31:0]      dtmcs;
  logic [1:0]       dmi_op_cap;
  logic             dmi_update, dtmcs_update, resp_accept;
  logic [ABITS-1:0] upd_addr;
  logic [31:0]      upd_data;
  logic [1:0]       upd_op;

  assign tms_s    = tms_sync_q[1];
  assign tdi_s    = tdi_sync_q[1];
  assign trst_s   = trst_sync_q[1];
  assign tck_rise = tck_sync_q[1] & ~tck_prev_q;
  assign tck_fall = ~tck_sync_q[1] & tck_prev_q;

  // TAP controller next state.
  always_comb begin
    state_d = state_q;
    if (!trst_s) begin
      state_d = StTlr;
    end else if (tck_rise) begin
      unique case (state_q)
        StTlr:     state_d = tms_s ? StTlr     : StRti;
        StRti:     state_d = tms_s ? StSelDr   : StRti;
        StSelDr:   state_d = tms_s ? StSelIr   : StCapDr;
        StCapDr:   state_d = tms_s ? StExit1Dr : StShiftDr;
        StShiftDr: state_d = tms_s ? StExit1Dr : StShiftDr;
        StExit1Dr: state_d = tms_s ? StUpdDr   : StPauseDr;
        StPauseDr: state_d = tms_s ? StExit2Dr : StPauseDr;
        StExit2Dr: state_d = tms_s ? StUpdDr   : StShiftDr;
        StUpdDr:   state_d = tms_s ? StSelDr   : StRti;
        StSelIr:   state_d = tms_s ? StTlr     : StCapIr;
        StCapIr:   state_d = tms_s ? StExit1Ir : StShiftIr;
        StShiftIr: state_d = tms_s ? StExit1Ir : StShiftIr;
        StExit1Ir: state_d = tms_s ? StUpdIr   : StPauseIr;
        StPauseIr: state_d = tms_s ? StExit2Ir : StPauseIr;
        StExit2Ir: state_d = tms_s ? StUpdIr   : StShiftIr;
        StUpdIr:   state_d = tms_s ? StSelDr   : StRti;
      endcase
    end
  end

  assign dtmcs      = {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, dmistat_q, 6'(ABITS), 4'd1};
  assign dmi_op_cap = busy_q ? 2'd3 : dmistat_q;

  // Capture value and active length of the data register selected by IR.
  always_comb begin
    dr_capture = '0;
    dr_msb     = '0;
    case (ir_q)
      IrIdcode: begin
        dr_capture = DrW'({IDCODE[31:1], 1'b1});
        dr_msb     = IdxW'(31);
      end
      IrDtmcs: begin
        dr_capture = DrW'(dtmcs);
        dr_msb     = IdxW'(31);
      end
      IrDmi: begin
        dr_capture = {last_addr_q, last_data_q, dmi_op_cap};
        dr_msb     = IdxW'(DrW - 1);
      end
      default: ;  // BYPASS: one bit, captures 0
    endcase
  end

  // Shift paths, IR update and TDO.
  always_comb begin
    ir_d       = ir_q;
    ir_shift_d = ir_shift_q;
    dr_shift_d = dr_shift_q;
    tdo_d      = tdo_q;
    tdo_en_d   = tdo_en_q;
    if (tck_rise) begin
      case (state_q)
        StCapIr:   ir_shift_d = 5'b00001;
        StShiftIr: ir_shift_d = {tdi_s, ir_shift_q[4:1]};
        StCapDr:   dr_shift_d = dr_capture;
        StShiftDr: begin
          // Bits above the active length stay zero from capture.
          dr_shift_d         = dr_shift_q >> 1;
          dr_shift_d[dr_msb] = tdi_s;
        end
        default: ;
      endcase
    end
    if (tck_fall) begin
      tdo_d    = (state_q == StShiftIr) ? ir_shift_q[0] : dr_shift_q[0];
      tdo_en_d = (state_q == StShiftDr) || (state_q == StShiftIr);
      if (state_q == StUpdIr) ir_d = ir_shift_q;
    end
    if (!trst_s) tdo_en_d = 1'b0;
    if (!trst_s || state_q == StTlr) ir_d = IrIdcode;
  end

  assign dmi_update   = tck_fall && (state_q == StUpdDr) && (ir_q == IrDmi);
  assign dtmcs_update = tck_fall && (state_q == StUpdDr) && (ir_q == IrDtmcs);
  assign upd_addr     = dr_shift_q[DrW-1 -: ABITS];
  assign upd_data     = dr_shift_q[33:2];
  assign upd_op       = dr_shift_q[1:0];
  // A response only counts once its request has been handed over (possibly this same clk).
  assign resp_accept  = dmi_resp_valid && busy_q && (!req_valid_q || dmi_req_ready);

  // DMI request/response bookkeeping.
  always_comb begin
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_op_d    = req_op_q;
    busy_d      = busy_q;
    dmistat_d   = dmistat_q;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;

    if (req_valid_q && dmi_req_ready) req_valid_d = 1'b0;
    if (resp_accept) begin
      busy_d      = 1'b0;
      last_data_d = dmi_resp_data;
      if (dmi_resp_op == 2'd2) dmistat_d = 2'd2;
    end

    if (dtmcs_update) begin
      if (dr_shift_q[16]) dmistat_d = 2'd0;
      if (dr_shift_q[17]) begin
        // Hard reset abandons the transaction; a late response then finds busy low.
        dmistat_d   = 2'd0;
        req_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    end

    if (dmi_update) begin
      if (busy_q) begin
        dmistat_d = 2'd3;
      end else if (dmistat_q == 2'd0 && (upd_op == 2'd1 || upd_op == 2'd2)) begin
        req_valid_d = 1'b1;
        busy_d      = 1'b1;
        req_addr_d  = upd_addr;
        req_data_d  = upd_data;
        req_op_d    = upd_op;
        last_addr_d = upd_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tck_sync_q  <= '0;
      tms_sync_q  <= '0;
      tdi_sync_q  <= '0;
      trst_sync_q <= '0;
      tck_prev_q  <= 1'b0;
      state_q     <= StTlr;
      ir_q        <= IrIdcode;
      ir_shift_q  <= '0;
      dr_shift_q  <= '0;
      tdo_q       <= 1'b0;
      tdo_en_q    <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_op_q    <= '0;
      busy_q      <= 1'b0;
      dmistat_q   <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      tck_sync_q  <= {tck_sync_q[0], tclk};
      tms_sync_q  <= {tms_sync_q[0], tms};
      tdi_sync_q  <= {tdi_sync_q[0], tdi};
      trst_sync_q <= {trst_sync_q[0], trst};
      tck_prev_q  <= tck_sync_q[1];
      state_q     <= state_d;
      ir_q        <= ir_d;
      ir_shift_q  <= ir_shift_d;
      dr_shift_q  <= dr_shift_d;
      tdo_q       <= tdo_d;
      tdo_en_q    <= tdo_en_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_op_q    <= req_op_d;
      busy_q      <= busy_d;
      dmistat_q   <= dmistat_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
    end
  end

  assign tdo            = tdo_q;
  assign tdo_en         = tdo_en_q;
  assign dmi_req_valid  = req_valid_q;
  assign dmi_req_addr   = req_addr_q;
  assign dmi_req_data   = req_data_q;
  assign dmi_req_op     = req_op_q;
  assign dmi_resp_ready = 1'b1;

endmodule

// File: tb/tb_jtag_dtm.sv
// Directed bench for jtag_dtm: a table of IR/DR scans with hand-computed captures, then
// hand-written DMI handshake, busy, sticky-error, hard-reset and trst sequences.
module tb_jtag_dtm;

  logic        clk = 1'b0;
  logic        rst_n, tclk, tms, tdi, trst, tdo, tdo_en;
  logic        dmi_req_valid, dmi_req_ready, dmi_resp_valid, dmi_resp_ready;
  logic [6:0]  dmi_req_addr;
  logic [31:0] dmi_req_data, dmi_resp_data;
  logic [1:0]  dmi_req_op, dmi_resp_op;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [63:0] Idcode = 64'h1000_0001;
  localparam logic [63:0] Dtmcs0 = 64'h0000_1071;

  jtag_dtm dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tclk           (tclk),
    .tms            (tms),
    .tdi            (tdi),
    .trst           (trst),
    .tdo            (tdo),
    .tdo_en         (tdo_en),
    .dmi_req_valid  (dmi_req_valid),
    .dmi_req_ready  (dmi_req_ready),
    .dmi_req_addr   (dmi_req_addr),
    .dmi_req_data   (dmi_req_data),
    .dmi_req_op     (dmi_req_op),
    .dmi_resp_valid (dmi_resp_valid),
    .dmi_resp_ready (dmi_resp_ready),
    .dmi_resp_data  (dmi_resp_data),
    .dmi_resp_op    (dmi_resp_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        is_ir;
    int          len;
    logic [63:0] din;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] dmi(input logic [6:0] a, input logic [31:0] d,
                                      input logic [1:0] op);
    return {23'b0, a, d, op};
  endfunction

  function automatic logic [63:0] req(input logic v, input logic [6:0] a,
                                      input logic [31:0] d, input logic [1:0] op);
    return {22'b0, v, a, d, op};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic is_ir, input int len,
                     input logic [63:0] din, input logic [63:0] exp);
    vec_t v;
    v.name = name; v.is_ir = is_ir; v.len = len; v.din = din; v.exp = exp;
    vecs.push_back(v);
  endtask

  // One TCK period; returns 5 clk after the falling edge so tdo/tdo_en have settled.
  task automatic tck(input logic m, input logic d);
    tms = m;
    tdi = d;
    #60 tclk = 1'b1;
    #60 tclk = 1'b0;
    #50;
  endtask

  // Run-Test/Idle -> scan IR or DR of len bits -> Update -> Run-Test/Idle.
  task automatic scan(input logic is_ir, input int len, input logic [63:0] din,
                      output logic [63:0] dout, output logic en_ok);
    dout  = '0;
    en_ok = 1'b1;
    tck(1'b1, 1'b0);
    if (is_ir) tck(1'b1, 1'b0);
    if (tdo_en !== 1'b0) en_ok = 1'b0;
    tck(1'b0, 1'b0);
    if (tdo_en !== 1'b0) en_ok = 1'b0;
    tck(1'b0, 1'b0);
    for (int i = 0; i < len; i++) begin
      dout[i] = tdo;
      if (tdo_en !== 1'b1) en_ok = 1'b0;
      tck(i == len - 1, din[i]);
    end
    if (tdo_en !== 1'b0) en_ok = 1'b0;
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
  endtask

  task automatic scan_chk(input string name, input logic is_ir, input int len,
                          input logic [63:0] din, input logic [63:0] exp);
    logic [63:0] dout;
    logic        en_ok;
    scan(is_ir, len, din, dout, en_ok);
    check(name, dout, exp);
  endtask

  task automatic ready_pulse();
    dmi_req_ready = 1'b1;
    #10 dmi_req_ready = 1'b0;
  endtask

  task automatic respond(input logic with_ready, input logic [31:0] d, input logic [1:0] op);
    dmi_req_ready  = with_ready;
    dmi_resp_valid = 1'b1;
    dmi_resp_data  = d;
    dmi_resp_op    = op;
    #10;
    dmi_req_ready  = 1'b0;
    dmi_resp_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] dout;
    logic        en_ok;

    rst_n = 1'b0; tclk = 1'b0; tms = 1'b1; tdi = 1'b0; trst = 1'b1;
    dmi_req_ready = 1'b0; dmi_resp_valid = 1'b0; dmi_resp_data = '0; dmi_resp_op = '0;
    #3;
    #20;
    check("reset tdo/tdo_en", {tdo, tdo_en}, 64'h0);
    check("reset req_valid", dmi_req_valid, 64'h0);
    check("resp_ready high", dmi_resp_ready, 64'h1);
    #50 rst_n = 1'b1;
    #50;

    for (int i = 0; i < 5; i++) tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);

    add("idcode after reset",   1'b0, 32, 64'h0,   Idcode);
    add("ir capture -> dtmcs",  1'b1, 5,  64'h10,  64'h01);
    add("dtmcs capture",        1'b0, 32, 64'h0,   Dtmcs0);
    add("ir -> 1f bypass",      1'b1, 5,  64'h1f,  64'h01);
    add("bypass 1f",            1'b0, 2,  64'h3,   64'h2);
    add("ir -> 05 bypass",      1'b1, 5,  64'h05,  64'h01);
    add("bypass 05",            1'b0, 2,  64'h1,   64'h2);
    add("ir -> idcode",         1'b1, 5,  64'h01,  64'h01);
    add("idcode again",         1'b0, 32, 64'hffff_ffff, Idcode);
    add("ir -> dmi",            1'b1, 5,  64'h11,  64'h01);
    add("dmi idle op0",         1'b0, 41, dmi(7'h55, 32'h1234_5678, 2'd0), 64'h0);
    add("dmi idle op3",         1'b0, 41, dmi(7'h2a, 32'h0, 2'd3), 64'h0);

    foreach (vecs[i]) begin
      scan(vecs[i].is_ir, vecs[i].len, vecs[i].din, dout, en_ok);
      check(vecs[i].name, dout, vecs[i].exp);
      check({vecs[i].name, " tdo_en"}, en_ok, 64'h1);
    end
    check("no request from op0/op3", dmi_req_valid, 64'h0);

    // Write, ready held low for 3 clk, then one-clk ready.
    scan_chk("dmi write capture", 1'b0, 41, dmi(7'h10, 32'h1, 2'd2), dmi(7'h0, 32'h0, 2'd0));
    check("write req issued", req(dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op),
          req(1'b1, 7'h10, 32'h1, 2'd2));
    for (int i = 0; i < 3; i++) begin
      #10;
      check("write req stable", req(dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op),
            req(1'b1, 7'h10, 32'h1, 2'd2));
    end
    ready_pulse();
    check("valid drops after ready", dmi_req_valid, 64'h0);
    respond(1'b0, 32'h0, 2'd0);

    // Read with ready and response in the same clk.
    scan_chk("dmi read capture", 1'b0, 41, dmi(7'h11, 32'h0, 2'd1), dmi(7'h10, 32'h0, 2'd0));
    check("read req issued", {dmi_req_valid, dmi_req_addr, dmi_req_op}, {1'b1, 7'h11, 2'd1});
    respond(1'b1, 32'hdead_beef, 2'd0);
    check("read done valid low", dmi_req_valid, 64'h0);
    scan_chk("dmi read result", 1'b0, 41, dmi(7'h0, 32'h0, 2'd0),
             dmi(7'h11, 32'hdead_beef, 2'd0));

    // Second update while busy.
    scan_chk("busy first write", 1'b0, 41, dmi(7'h05, 32'haa, 2'd2),
             dmi(7'h11, 32'hdead_beef, 2'd0));
    scan_chk("busy capture op3", 1'b0, 41, dmi(7'h06, 32'hbb, 2'd2),
             dmi(7'h05, 32'hdead_beef, 2'd3));
    check("only first request", req(dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op),
          req(1'b1, 7'h05, 32'haa, 2'd2));
    ready_pulse();
    respond(1'b0, 32'h1234, 2'd0);
    scan_chk("sticky busy error", 1'b0, 41, dmi(7'h0, 32'h0, 2'd0), dmi(7'h05, 32'h1234, 2'd3));
    scan_chk("ir -> dtmcs (1)", 1'b1, 5, 64'h10, 64'h01);
    scan_chk("dtmcs dmistat=3", 1'b0, 32, 64'h1_0000, 64'h1c71);
    scan_chk("dtmcs after dmireset", 1'b0, 32, 64'h0, Dtmcs0);

    // trst during Shift-DR keeps a pending request.
    scan_chk("ir -> dmi (2)", 1'b1, 5, 64'h11, 64'h01);
    scan_chk("pending write", 1'b0, 41, dmi(7'h07, 32'h77, 2'd2), dmi(7'h05, 32'h1234, 2'd0));
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b1);
    tck(1'b0, 1'b1);
    trst = 1'b0;
    #80 trst = 1'b1;
    #50;
    check("trst keeps request", {dmi_req_valid, dmi_req_addr}, {1'b1, 7'h07});
    tck(1'b0, 1'b0);
    scan_chk("idcode after trst", 1'b0, 32, 64'h0, Idcode);
    check("request still pending", {dmi_req_valid, dmi_req_addr}, {1'b1, 7'h07});

    // dmihardreset drops the request; the late response is ignored.
    scan_chk("ir -> dtmcs (2)", 1'b1, 5, 64'h10, 64'h01);
    scan_chk("dtmcs hardreset", 1'b0, 32, 64'h2_0000, Dtmcs0);
    check("hardreset drops valid", dmi_req_valid, 64'h0);
    respond(1'b0, 32'hffff_ffff, 2'd2);
    scan_chk("ir -> dmi (3)", 1'b1, 5, 64'h11, 64'h01);
    scan_chk("stray resp ignored", 1'b0, 41, dmi(7'h0, 32'h0, 2'd0), dmi(7'h07, 32'h1234, 2'd0));

    // Failed response sets sticky dmistat=2, which blocks further requests.
    scan_chk("read for failure", 1'b0, 41, dmi(7'h08, 32'h0, 2'd1), dmi(7'h07, 32'h1234, 2'd0));
    respond(1'b1, 32'h5555, 2'd2);
    scan_chk("failed capture", 1'b0, 41, dmi(7'h09, 32'h99, 2'd2), dmi(7'h08, 32'h5555, 2'd2));
    #10;
    check("blocked by dmistat", dmi_req_valid, 64'h0);
    scan_chk("ir -> dtmcs (3)", 1'b1, 5, 64'h10, 64'h01);
    scan_chk("dtmcs dmistat=2", 1'b0, 32, 64'h0, 64'h1871);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
